// File: rtl/uart_tx_queue.sv
// Byte FIFO in front of the uart_shim register port: polls the status word, writes data when ready.
// Build option UART_TXQ_CRLF_EN: a queued 8'h0A is preceded on the wire by an inserted 8'h0D.
module uart_tx_queue #(
  parameter int unsigned DEPTH        = 16,
  parameter logic [2:0]  STATUS_ADDR  = 3'd1,
  parameter logic [2:0]  DATA_ADDR    = 3'd0,
  parameter int unsigned TX_READY_BIT = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  input  logic [7:0]             push_data,
  output logic                   push_ready,
  output logic [2:0]             uart_addr,
  output logic                   uart_write_enable,
  output logic [31:0]            uart_write_data,
  input  logic [31:0]            uart_read_result,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  localparam int unsigned     PtrW      = $clog2(DEPTH);
  localparam int unsigned     CntW      = PtrW + 1;
  localparam logic [CntW-1:0] CountFull = CntW'(DEPTH);
  localparam logic [4:0]      ReadyIdx  = 5'(TX_READY_BIT);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPoll  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StGuard = 2'd3;

  // FIFO storage and bookkeeping
  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_fire;
  logic            pop;
  logic [7:0]      head;

  // Sequencer
  logic [1:0]  state_q, state_d;
  logic        tx_ready;
  logic [7:0]  send_byte;
  logic [2:0]  addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;

  logic unused_read_bits;
  assign unused_read_bits = ^uart_read_result;

  assign tx_ready   = uart_read_result[ReadyIdx];
  assign head       = mem_q[rd_ptr_q];
  assign push_ready = (count_q != CountFull);
  assign push_fire  = push_valid && push_ready;

`ifdef UART_TXQ_CRLF_EN
  // cr_sent marks that the inserted CR for the current head 8'h0A has already gone out.
  logic cr_sent_q, cr_sent_d;
  logic insert_cr;

  assign insert_cr = (head == 8'h0A) && !cr_sent_q;
  assign send_byte = insert_cr ? 8'h0D : head;
  assign pop       = (state_q == StWrite) && !insert_cr;

  always_comb begin
    cr_sent_d = cr_sent_q;
    if (pop) begin
      cr_sent_d = 1'b0;
    end else if ((state_q == StWrite) && insert_cr) begin
      cr_sent_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cr_sent_q <= 1'b0;
    end else begin
      cr_sent_q <= cr_sent_d;
    end
  end
`else
  assign send_byte = head;
  assign pop       = (state_q == StWrite);
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_fire) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push_fire, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (count_q != '0) state_d = StPoll;
      StPoll:  if (tx_ready) state_d = StWrite;
      StWrite: state_d = StGuard;
      StGuard: state_d = (count_q != '0) ? StPoll : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Shim-facing outputs are registered, so they are derived from the state being entered.
  always_comb begin
    we_d    = (state_d == StWrite);
    addr_d  = we_d ? DATA_ADDR : STATUS_ADDR;
    wdata_d = we_d ? {24'b0, send_byte} : wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StIdle;
      addr_q   <= STATUS_ADDR;
      we_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
    end
  end

  assign uart_addr         = addr_q;
  assign uart_write_enable = we_q;
  assign uart_write_data   = wdata_q;
  assign count             = count_q;
  assign busy              = (count_q != '0) || (state_q != StIdle);

endmodule
